// File: rtl/m92_dma_pkg.sv
// Shared definitions for the sprite-list copy engine: FSM states and the write-strobe pattern.
package m92_dma_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COPY   = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } dma_state_t;

   localparam logic [1:0] DMA_WE_WORD = 2'b11;

endpackage

// File: rtl/sprite_list_dma_if.sv
// Bus bundle between the sprite-list DMA, the object RAM read port and the sprite buffer write port.
interface sprite_list_dma_if #(
   parameter int ADDR_W = 10
);
   logic              start;
   logic              busy;
   logic              done;
   logic              bank;
   logic [ADDR_W-1:0] src_addr;
   logic [15:0]       src_q;
   logic [ADDR_W:0]   dst_addr;
   logic [15:0]       dst_data;
   logic [1:0]        dst_we;

   modport master (
      input  start, src_q,
      output busy, done, bank, src_addr, dst_addr, dst_data, dst_we
   );

   modport slave (
      output start, src_q,
      input  busy, done, bank, src_addr, dst_addr, dst_data, dst_we
   );
endinterface

// File: rtl/sprite_list_dma.sv
// Copies WORD_COUNT words from the object RAM into the renderer's idle sprite buffer bank,
// then flips the bank.
module sprite_list_dma
   import m92_dma_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int WORD_COUNT = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce,
   sprite_list_dma_if.master bus
);

   localparam logic [ADDR_W:0] CNT_END = (ADDR_W+1)'(WORD_COUNT);
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   dma_state_t        state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0] src_addr_q, src_addr_d;
   logic              src_vld_q, src_vld_d;
   logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
   logic              s1_vld_q, s1_vld_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [15:0]       cap_q, cap_d;
   logic [ADDR_W:0]   dst_addr_q, dst_addr_d;
   logic [15:0]       dst_data_q, dst_data_d;
   logic [1:0]        dst_we_q, dst_we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              bank_q, bank_d;

   always_comb begin
      // rd_addr_q mirrors the address the RAM latched, so src_q always belongs to it; cap_q
      // keeps the word for stage 1 even when ce gaps let the source run ahead.
      rd_addr_d  = src_addr_q;
      cap_d      = (rd_addr_q == s1_addr_q) ? bus.src_q : cap_q;

      state_d    = state_q;
      cnt_d      = cnt_q;
      src_addr_d = src_addr_q;
      src_vld_d  = 1'b0;
      s1_addr_d  = src_addr_q;
      s1_vld_d   = src_vld_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      bank_d     = bank_q;

      if (s1_vld_q) begin
         dst_data_d = cap_d;
         dst_addr_d = {~bank_q, s1_addr_q};
         dst_we_d   = DMA_WE_WORD;
      end else begin
         dst_data_d = dst_data_q;
         dst_addr_d = dst_addr_q;
         dst_we_d   = 2'b00;
      end

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d    = COPY;
               busy_d     = 1'b1;
               src_addr_d = '0;
               src_vld_d  = 1'b1;
               cnt_d      = CNT_ONE;
            end else begin
               state_d    = IDLE;
            end
         end
         COPY: begin
            if (cnt_q == CNT_END) begin
               state_d    = DRAIN;
            end else begin
               src_addr_d = cnt_q[ADDR_W-1:0];
               src_vld_d  = 1'b1;
               cnt_d      = cnt_q + CNT_ONE;
            end
         end
         DRAIN: state_d = FINISH;
         FINISH: begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            bank_d  = ~bank_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         src_addr_q <= '0;
         src_vld_q  <= 1'b0;
         s1_addr_q  <= '0;
         s1_vld_q   <= 1'b0;
         rd_addr_q  <= '0;
         cap_q      <= 16'h0000;
         dst_addr_q <= '0;
         dst_data_q <= 16'h0000;
         dst_we_q   <= 2'b00;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         bank_q     <= 1'b0;
      end else begin
         rd_addr_q <= rd_addr_d;
         cap_q     <= cap_d;
         if (ce) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            src_addr_q <= src_addr_d;
            src_vld_q  <= src_vld_d;
            s1_addr_q  <= s1_addr_d;
            s1_vld_q   <= s1_vld_d;
            dst_addr_q <= dst_addr_d;
            dst_data_q <= dst_data_d;
            dst_we_q   <= dst_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bank_q     <= bank_d;
         end
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.bank     = bank_q;
   assign bus.src_addr = src_addr_q;
   assign bus.dst_addr = dst_addr_q;
   assign bus.dst_data = dst_data_q;
   assign bus.dst_we   = dst_we_q;

endmodule

// File: tb/tb_sprite_list_dma.sv
// Directed bench for sprite_list_dma: two instances (8-word full range and 1-word) with behavioural RAMs.
module tb_sprite_list_dma;

   localparam int AW = 3;

   logic clk = 1'b0;
   logic reset;
   logic ce;
   logic clr;
   logic tgl;
   int   n_vec = 0;
   int   n_bad = 0;
   int   clk_n = 0;

   always #5 clk = ~clk;

   sprite_list_dma_if #(.ADDR_W(AW)) if0 ();
   sprite_list_dma_if #(.ADDR_W(AW)) if1 ();

   sprite_list_dma #(.ADDR_W(AW), .WORD_COUNT(8)) dut0 (
      .clk(clk), .reset(reset), .ce(ce), .bus(if0)
   );
   sprite_list_dma #(.ADDR_W(AW), .WORD_COUNT(1)) dut1 (
      .clk(clk), .reset(reset), .ce(1'b1), .bus(if1)
   );

   logic [15:0] obj  [0:7];
   logic [15:0] buf0 [0:15];
   logic [15:0] buf1 [0:15];
   int          wr0, ord0, wrb1, wr1;
   logic [2:0]  nxt0;

   initial begin
      for (int i = 0; i < 8; i++) obj[i] = 16'hA000 + 16'(i);
   end

   // Object RAM read ports, sprite buffer write ports, and the ce-qualified write log.
   always @(posedge clk) begin
      if0.src_q <= obj[if0.src_addr];
      if1.src_q <= obj[if1.src_addr];
      if (clr) begin
         for (int i = 0; i < 16; i++) begin
            buf0[i] <= 16'h0000;
            buf1[i] <= 16'h0000;
         end
         wr0 <= 0; ord0 <= 0; wrb1 <= 0; wr1 <= 0; nxt0 <= 3'd0;
      end else begin
         if (if0.dst_we == 2'b11) buf0[if0.dst_addr] <= if0.dst_data;
         if (if1.dst_we == 2'b11) begin
            buf1[if1.dst_addr] <= if1.dst_data;
            wr1 <= wr1 + 1;
         end
         if (ce && if0.dst_we == 2'b11) begin
            wr0  <= wr0 + 1;
            nxt0 <= nxt0 + 3'd1;
            if (if0.dst_addr[2:0] != nxt0) ord0 <= ord0 + 1;
            if (if0.dst_addr[3]) wrb1 <= wrb1 + 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      clk_n++;
   endtask

   task automatic ce_edge();
      if (tgl) begin
         ce = 1'b0;
         tick();
         ce = 1'b1;
      end
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1; clr = 1'b1; ce = 1'b1; tgl = 1'b0;
      if0.start = 1'b0; if1.start = 1'b0;
      tick(); tick();
      reset = 1'b0; clr = 1'b0;
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      while (if0.done !== 1'b1 && n < max) begin
         ce_edge();
         n++;
      end
   endtask

   task automatic test_reset();
      ce = 1'b1; tgl = 1'b0; clr = 1'b1; reset = 1'b1;
      if0.start = 1'b1; if1.start = 1'b1;
      tick(); tick();
      n_vec++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", if0.busy); end
      n_vec++; if (if0.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", if0.done); end
      n_vec++; if (if0.bank !== 1'b0) begin n_bad++; $display("FAIL reset_bank: got %b want 0", if0.bank); end
      n_vec++; if (if0.src_addr !== 3'd0) begin n_bad++; $display("FAIL reset_src_addr: got %h want 0", if0.src_addr); end
      n_vec++; if (if0.dst_addr !== 4'd0) begin n_bad++; $display("FAIL reset_dst_addr: got %h want 0", if0.dst_addr); end
      n_vec++; if (if0.dst_data !== 16'h0000) begin n_bad++; $display("FAIL reset_dst_data: got %h want 0000", if0.dst_data); end
      n_vec++; if (if0.dst_we !== 2'b00) begin n_bad++; $display("FAIL reset_dst_we: got %b want 00", if0.dst_we); end
      n_vec++; if (if1.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_wc1: got %b want 0", if1.busy); end
      reset = 1'b0; clr = 1'b0; if0.start = 1'b0; if1.start = 1'b0;
   endtask

   task automatic test_basic();
      int n;
      do_reset();
      if0.start = 1'b1; ce_edge(); if0.start = 1'b0;
      n_vec++; if (if0.busy !== 1'b1 || if0.src_addr !== 3'd0) begin n_bad++; $display("FAIL basic_e0: busy=%b src_addr=%h want 1/0", if0.busy, if0.src_addr); end
      ce_edge();
      n_vec++; if (if0.src_addr !== 3'd1 || if0.dst_we !== 2'b00) begin n_bad++; $display("FAIL basic_e1: src_addr=%h we=%b want 1/00", if0.src_addr, if0.dst_we); end
      ce_edge();
      n_vec++; if (if0.dst_we !== 2'b11 || if0.dst_addr !== 4'h8 || if0.dst_data !== 16'hA000) begin
         n_bad++; $display("FAIL basic_first_write: we=%b addr=%h data=%h want 11/8/a000", if0.dst_we, if0.dst_addr, if0.dst_data);
      end
      wait_done(40, n);
      n_vec++; if (n + 2 !== 10) begin n_bad++; $display("FAIL basic_done_latency: got %0d want 10", n + 2); end
      n_vec++; if (if0.busy !== 1'b0 || if0.bank !== 1'b1) begin n_bad++; $display("FAIL basic_finish: busy=%b bank=%b want 0/1", if0.busy, if0.bank); end
      n_vec++; if (if0.src_addr !== 3'd7) begin n_bad++; $display("FAIL basic_src_stop: got %h want 7", if0.src_addr); end
      n_vec++; if (wr0 !== 8 || ord0 !== 0 || wrb1 !== 8) begin n_bad++; $display("FAIL basic_writes: cnt=%0d order_err=%0d bank1=%0d want 8/0/8", wr0, ord0, wrb1); end
      for (int i = 0; i < 8; i++) begin
         n_vec++; if (buf0[8+i] !== 16'hA000 + 16'(i)) begin n_bad++; $display("FAIL basic_buf[%0d]: got %h want %h", 8+i, buf0[8+i], 16'hA000 + 16'(i)); end
      end
      ce_edge();
      n_vec++; if (if0.done !== 1'b0) begin n_bad++; $display("FAIL basic_done_clear: got %b want 0", if0.done); end
   endtask

   task automatic test_ce_toggle();
      int n;
      int c_acc;
      do_reset();
      tgl = 1'b1;
      if0.start = 1'b1; ce_edge(); if0.start = 1'b0;
      c_acc = clk_n;
      wait_done(40, n);
      n_vec++; if (n !== 10) begin n_bad++; $display("FAIL tgl_done_ce: got %0d want 10", n); end
      n_vec++; if (clk_n - c_acc !== 20) begin n_bad++; $display("FAIL tgl_done_clk: got %0d want 20", clk_n - c_acc); end
      n_vec++; if (wr0 !== 8 || ord0 !== 0 || if0.bank !== 1'b1) begin n_bad++; $display("FAIL tgl_writes: cnt=%0d order_err=%0d bank=%b want 8/0/1", wr0, ord0, if0.bank); end
      for (int i = 0; i < 8; i++) begin
         n_vec++; if (buf0[8+i] !== 16'hA000 + 16'(i)) begin n_bad++; $display("FAIL tgl_buf[%0d]: got %h want %h", 8+i, buf0[8+i], 16'hA000 + 16'(i)); end
      end
      tgl = 1'b0; ce = 1'b0; tick();
      n_vec++; if (if0.done !== 1'b1) begin n_bad++; $display("FAIL tgl_hold_done: got %b want 1", if0.done); end
      ce = 1'b1; ce_edge();
      n_vec++; if (if0.done !== 1'b0) begin n_bad++; $display("FAIL tgl_done_clear: got %b want 0", if0.done); end
   endtask

   task automatic test_start_ignored();
      int n;
      do_reset();
      if0.start = 1'b1; ce_edge(); if0.start = 1'b0;
      ce_edge(); ce_edge();
      if0.start = 1'b1; ce_edge(); if0.start = 1'b0;
      ce_edge();
      if0.start = 1'b1; ce_edge(); if0.start = 1'b0;
      wait_done(40, n);
      n_vec++; if (n !== 5) begin n_bad++; $display("FAIL ign_done_latency: got %0d want 5", n); end
      n_vec++; if (if0.bank !== 1'b1) begin n_bad++; $display("FAIL ign_bank: got %b want 1", if0.bank); end
      for (int i = 0; i < 4; i++) ce_edge();
      n_vec++; if (if0.busy !== 1'b0 || if0.bank !== 1'b1 || wr0 !== 8) begin
         n_bad++; $display("FAIL ign_single: busy=%b bank=%b writes=%0d want 0/1/8", if0.busy, if0.bank, wr0);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      if0.start = 1'b1; ce_edge(); if0.start = 1'b0;
      ce_edge(); ce_edge(); ce_edge();
      reset = 1'b1; ce_edge(); reset = 1'b0;
      n_vec++; if (if0.busy !== 1'b0 || if0.bank !== 1'b0 || if0.dst_we !== 2'b00 || if0.src_addr !== 3'd0) begin
         n_bad++; $display("FAIL mid_reset_out: busy=%b bank=%b we=%b src=%h want 0/0/00/0", if0.busy, if0.bank, if0.dst_we, if0.src_addr);
      end
      n_vec++; if (wr0 !== 2) begin n_bad++; $display("FAIL mid_reset_writes: got %0d want 2", wr0); end
      n_vec++; if (buf0[8] !== 16'hA000 || buf0[9] !== 16'hA001 || buf0[10] !== 16'h0000) begin
         n_bad++; $display("FAIL mid_reset_buf: got %h %h %h want a000 a001 0000", buf0[8], buf0[9], buf0[10]);
      end
      clr = 1'b1; ce_edge(); clr = 1'b0;
      if0.start = 1'b1; ce_edge(); if0.start = 1'b0;
      wait_done(40, n);
      n_vec++; if (n !== 10 || if0.bank !== 1'b1 || wr0 !== 8) begin
         n_bad++; $display("FAIL mid_rerun: latency=%0d bank=%b writes=%0d want 10/1/8", n, if0.bank, wr0);
      end
      for (int i = 0; i < 8; i++) begin
         n_vec++; if (buf0[8+i] !== 16'hA000 + 16'(i)) begin n_bad++; $display("FAIL mid_buf[%0d]: got %h want %h", 8+i, buf0[8+i], 16'hA000 + 16'(i)); end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      do_reset();
      if0.start = 1'b1; ce_edge();
      wait_done(40, n);
      n_vec++; if (n !== 10 || if0.bank !== 1'b1) begin n_bad++; $display("FAIL b2b_first: latency=%0d bank=%b want 10/1", n, if0.bank); end
      ce_edge();
      n_vec++; if (if0.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart: busy=%b want 1", if0.busy); end
      wait_done(40, n);
      if0.start = 1'b0;
      n_vec++; if (n !== 10 || if0.bank !== 1'b0) begin n_bad++; $display("FAIL b2b_second: latency=%0d bank=%b want 10/0", n, if0.bank); end
      n_vec++; if (wr0 !== 16 || wrb1 !== 8 || ord0 !== 0) begin n_bad++; $display("FAIL b2b_writes: cnt=%0d bank1=%0d order_err=%0d want 16/8/0", wr0, wrb1, ord0); end
      for (int i = 0; i < 8; i++) begin
         n_vec++; if (buf0[i] !== 16'hA000 + 16'(i)) begin n_bad++; $display("FAIL b2b_buf0[%0d]: got %h want %h", i, buf0[i], 16'hA000 + 16'(i)); end
      end
      ce_edge();
      n_vec++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: busy=%b want 0", if0.busy); end
   endtask

   task automatic test_word_count_one();
      do_reset();
      if1.start = 1'b1; tick(); if1.start = 1'b0;
      n_vec++; if (if1.busy !== 1'b1) begin n_bad++; $display("FAIL wc1_busy: got %b want 1", if1.busy); end
      tick();
      n_vec++; if (if1.dst_we !== 2'b00) begin n_bad++; $display("FAIL wc1_e1_we: got %b want 00", if1.dst_we); end
      tick();
      n_vec++; if (if1.dst_we !== 2'b11 || if1.dst_addr !== 4'h8 || if1.dst_data !== 16'hA000) begin
         n_bad++; $display("FAIL wc1_write: we=%b addr=%h data=%h want 11/8/a000", if1.dst_we, if1.dst_addr, if1.dst_data);
      end
      tick();
      n_vec++; if (if1.done !== 1'b1 || if1.busy !== 1'b0 || if1.bank !== 1'b1) begin
         n_bad++; $display("FAIL wc1_done: done=%b busy=%b bank=%b want 1/0/1", if1.done, if1.busy, if1.bank);
      end
      tick();
      n_vec++; if (if1.done !== 1'b0 || wr1 !== 1 || buf1[8] !== 16'hA000 || buf1[9] !== 16'h0000) begin
         n_bad++; $display("FAIL wc1_after: done=%b writes=%0d buf8=%h buf9=%h want 0/1/a000/0000", if1.done, wr1, buf1[8], buf1[9]);
      end
   endtask

   initial begin
      reset = 1'b1; ce = 1'b1; clr = 1'b1; tgl = 1'b0;
      if0.start = 1'b0; if1.start = 1'b0;
      test_reset();
      test_basic();
      test_ce_toggle();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      test_word_count_one();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach summary");
      $fatal(1);
   end

endmodule
